reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  In-order reorder buffer (ROB) fed directly by the Decode->ROB pipeline register.
//  - Allocates one entry per valid decoded instruction and returns its tag.
//  - Marks entries done on execution writeback.
//  - Retires entries in program order to the register file / store path.
//  - Asserts halt back to Decode when full.
// PARAMETERS
//  TAG_WIDTH   4    entry tag width; DEPTH = 2**TAG_WIDTH entries
//  DATA_WIDTH  32   result/immediate width
//  RF_WIDTH    5    architectural register index width
//  EXEC_WIDTH  4    execution-unit ID width
// PORTS
//  clk              in   1            clock, all state updates on posedge
//  rst              in   1            synchronous, active-low reset (rst==0 resets)
//  flush            in   1            synchronous flush, empties ROB
//  RType_valid_ROB  in   1            R-type instruction presented
//  IType_valid_ROB  in   1            I-type instruction presented
//  SType_valid_ROB  in   1            S-type (store) instruction presented
//  rd_ROB           in   RF_WIDTH     destination register
//  imm_ROB          in   DATA_WIDTH   immediate, stored with entry
//  executionID_ROB  in   EXEC_WIDTH   target execution unit
//  alloc_tag        out  TAG_WIDTH    tag given to the instruction presented this cycle (= tail)
//  halt             out  1            ROB full; upstream must hold
//  count            out  TAG_WIDTH+1  occupied entries, 0..DEPTH
//  wb_valid         in   1            execution writeback
//  wb_tag           in   TAG_WIDTH    entry being completed
//  wb_data          in   DATA_WIDTH   result value
//  commit_ready     in   1            retire sink accepts this cycle
//  commit_valid     out  1            head entry is valid and done
//  commit_rd        out  RF_WIDTH     head destination register
//  commit_data      out  DATA_WIDTH   head result
//  commit_is_store  out  1            head is S-type
//  commit_execID    out  EXEC_WIDTH   head execution-unit ID
// BEHAVIOUR
//  State
//  - Per entry: valid, done, type[1:0], rd, imm, execID, data.
//  - head/tail pointers of TAG_WIDTH bits; wrap modulo DEPTH naturally.
//  - count register tracks occupancy.
//  Reset and flush
//  - Priority: rst==0 > flush > normal.
//  - Either one clears all valid/done bits, head=tail=0, count=0.
//  - All registered outputs go to 0.
//  - Reset mid-operation discards every entry; no commit in that cycle.
//  Allocation
//  - alloc = (RType|IType|SType)_valid_ROB & ~halt.
//  - On posedge: entry[tail] <= {valid=1, done=0, type, fields}; tail++.
//  - More than one type valid at once is illegal; the stored type uses priority S > I > R.
//  Halt
//  - halt = (count==DEPTH); combinational from registered count.
//  - A commit in the same cycle does not lift halt until the next cycle.
//  Writeback
//  - If wb_valid & valid[wb_tag]: done <= 1 and data <= wb_data.
//  - Writeback to an invalid entry is ignored.
//  - Writeback to the tail in the same cycle as that slot is allocated is illegal.
//  Commit
//  - commit_* are combinational from entry[head]: commit_valid = valid[head] & done[head].
//  - Retire = commit_valid & commit_ready: valid[head] <= 0, head++.
//  - Writeback in cycle N makes the entry committable in cycle N+1 at the earliest (1-cycle latency).
//  - Empty ROB: commit_valid = 0.
//  Count
//  - count <= count + alloc - retire.
//  - Simultaneous alloc and retire leaves count unchanged, including at count==DEPTH-1.
// TESTING
//  1. Reset: hold rst=0 for 2 cycles with inputs active -> count=0, halt=0, commit_valid=0, alloc_tag=0.
//  2. Single op: R-type rd=5; wb tag0 data=0xDEAD; commit_ready=1
//     -> commit_valid=1 one cycle after wb, commit_rd=5, commit_data=0xDEAD, count returns to 0.
//  3. Fill: 16 allocs with no wb -> count=16, halt=1; a 17th valid is not allocated; alloc_tag wraps to 0.
//  4. Out-of-order wb: alloc tags 0,1,2; wb 2 then 1 then 0
//     -> commits in order 0,1,2 only after tag0 is done; commit_is_store=1 for the S-type.
//  5. Full + simultaneous: at count=16, retire head while a valid is presented
//     -> no alloc that cycle, count=15, halt=0 the next cycle.
//  6. Flush with 7 entries, 3 done -> next cycle count=0, commit_valid=0;
//     a late wb to an old tag is ignored; the next alloc gets tag 0.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// Decode/writeback/retire bundle shared between the pipeline side and the ROB.
// The pipeline side (master) presents instructions, writebacks and retire
// acceptance. The ROB side (slave) returns the tag, occupancy and head entry.
interface reorder_buffer_if #(
  parameter int TAG_WIDTH  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int RF_WIDTH   = 5,
  parameter int EXEC_WIDTH = 4
);
  // Decode -> ROB
  logic                  RType_valid_ROB;
  logic                  IType_valid_ROB;
  logic                  SType_valid_ROB;
  logic [RF_WIDTH-1:0]   rd_ROB;
  logic [DATA_WIDTH-1:0] imm_ROB;
  logic [EXEC_WIDTH-1:0] executionID_ROB;
  logic [TAG_WIDTH-1:0]  alloc_tag;
  logic                  halt;
  logic [TAG_WIDTH:0]    count;
  // Execution writeback
  logic                  wb_valid;
  logic [TAG_WIDTH-1:0]  wb_tag;
  logic [DATA_WIDTH-1:0] wb_data;
  // Retire
  logic                  commit_ready;
  logic                  commit_valid;
  logic [RF_WIDTH-1:0]   commit_rd;
  logic [DATA_WIDTH-1:0] commit_data;
  logic [DATA_WIDTH-1:0] commit_imm;
  logic                  commit_is_store;
  logic [EXEC_WIDTH-1:0] commit_execID;

  modport master (
    output RType_valid_ROB, IType_valid_ROB, SType_valid_ROB,
    output rd_ROB, imm_ROB, executionID_ROB,
    output wb_valid, wb_tag, wb_data, commit_ready,
    input  alloc_tag, halt, count,
    input  commit_valid, commit_rd, commit_data, commit_imm,
    input  commit_is_store, commit_execID
  );

  modport slave (
    input  RType_valid_ROB, IType_valid_ROB, SType_valid_ROB,
    input  rd_ROB, imm_ROB, executionID_ROB,
    input  wb_valid, wb_tag, wb_data, commit_ready,
    output alloc_tag, halt, count,
    output commit_valid, commit_rd, commit_data, commit_imm,
    output commit_is_store, commit_execID
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates at tail, completes on writeback,
// retires from head in program order, and halts Decode when full.
module reorder_buffer #(
  parameter int TAG_WIDTH  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int RF_WIDTH   = 5,
  parameter int EXEC_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,    // active-low, synchronous
  input  logic             flush,
  reorder_buffer_if.slave  bus
);
  localparam int DEPTH = 2 ** TAG_WIDTH;
  localparam logic [TAG_WIDTH:0] FULL_COUNT = (TAG_WIDTH + 1)'(DEPTH);

  // Entry type encoding
  localparam logic [1:0] TYPE_R = 2'd0;
  localparam logic [1:0] TYPE_I = 2'd1;
  localparam logic [1:0] TYPE_S = 2'd2;

  logic [TAG_WIDTH-1:0] r_head;
  logic [TAG_WIDTH-1:0] r_tail;
  logic [TAG_WIDTH:0]   r_count;

  logic [DEPTH-1:0]      w_valid;
  logic [DEPTH-1:0]      w_done;
  logic [1:0]            w_type   [DEPTH];
  logic [RF_WIDTH-1:0]   w_rd     [DEPTH];
  logic [DATA_WIDTH-1:0] w_imm    [DEPTH];
  logic [EXEC_WIDTH-1:0] w_execid [DEPTH];
  logic [DATA_WIDTH-1:0] w_data   [DEPTH];

  logic       w_halt;
  logic       w_any_valid;
  logic       w_alloc;
  logic [1:0] w_alloc_type;
  logic       w_commit_valid;
  logic       w_retire;

  // Halt comes from the registered count only, so a retire in the full
  // cycle frees space for the following cycle, not this one.
  assign w_halt       = (r_count == FULL_COUNT);
  assign w_any_valid  = bus.RType_valid_ROB | bus.IType_valid_ROB | bus.SType_valid_ROB;
  assign w_alloc      = w_any_valid & ~w_halt;
  // Several valids at once is illegal upstream; resolve S > I > R anyway.
  assign w_alloc_type = bus.SType_valid_ROB ? TYPE_S :
                        bus.IType_valid_ROB ? TYPE_I : TYPE_R;

  assign w_commit_valid = w_valid[r_head] & w_done[r_head];
  assign w_retire       = w_commit_valid & bus.commit_ready;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic                  r_valid;
      logic                  r_done;
      logic [1:0]            r_type;
      logic [RF_WIDTH-1:0]   r_rd;
      logic [DATA_WIDTH-1:0] r_imm;
      logic [EXEC_WIDTH-1:0] r_execid;
      logic [DATA_WIDTH-1:0] r_data;
      logic                  w_alloc_hit;
      logic                  w_wb_hit;
      logic                  w_retire_hit;

      assign w_alloc_hit  = w_alloc && (r_tail == TAG_WIDTH'(gi));
      assign w_wb_hit     = bus.wb_valid && r_valid && (bus.wb_tag == TAG_WIDTH'(gi));
      assign w_retire_hit = w_retire && (r_head == TAG_WIDTH'(gi));

      // Entry lifecycle: allocate -> done on writeback -> freed on retire
      always_ff @(posedge clk) begin
        if (!rst || flush) begin
          r_valid <= 1'b0;
          r_done  <= 1'b0;
        end else if (w_alloc_hit) begin
          r_valid <= 1'b1;
          r_done  <= 1'b0;
        end else begin
          if (w_retire_hit) r_valid <= 1'b0;
          if (w_wb_hit)     r_done  <= 1'b1;
        end
      end

      // Entry payload: captured at allocation, result filled at writeback
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_type   <= TYPE_R;
          r_rd     <= '0;
          r_imm    <= '0;
          r_execid <= '0;
          r_data   <= '0;
        end else if (w_alloc_hit) begin
          r_type   <= w_alloc_type;
          r_rd     <= bus.rd_ROB;
          r_imm    <= bus.imm_ROB;
          r_execid <= bus.executionID_ROB;
          r_data   <= '0;
        end else if (w_wb_hit) begin
          r_data   <= bus.wb_data;
        end
      end

      assign w_valid[gi]  = r_valid;
      assign w_done[gi]   = r_done;
      assign w_type[gi]   = r_type;
      assign w_rd[gi]     = r_rd;
      assign w_imm[gi]    = r_imm;
      assign w_execid[gi] = r_execid;
      assign w_data[gi]   = r_data;
    end
  endgenerate

  // Head/tail pointers wrap naturally; count tracks occupancy
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_alloc)  r_tail <= r_tail + 1'b1;
      if (w_retire) r_head <= r_head + 1'b1;
      r_count <= r_count + (TAG_WIDTH + 1)'(w_alloc) - (TAG_WIDTH + 1)'(w_retire);
    end
  end

  assign bus.alloc_tag       = r_tail;
  assign bus.halt            = w_halt;
  assign bus.count           = r_count;
  assign bus.commit_valid    = w_commit_valid;
  assign bus.commit_rd       = w_rd[r_head];
  assign bus.commit_data     = w_data[r_head];
  assign bus.commit_imm      = w_imm[r_head];
  assign bus.commit_is_store = (w_type[r_head] == TYPE_S);
  assign bus.commit_execID   = w_execid[r_head];
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: a queue-based program-order model checked on
// every negedge, plus directed scenarios with literal expectations.
module tb_reorder_buffer;
  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  reorder_buffer_if #(.TAG_WIDTH(4), .DATA_WIDTH(32), .RF_WIDTH(5), .EXEC_WIDTH(4)) rob_bus ();

  reorder_buffer #(.TAG_WIDTH(4), .DATA_WIDTH(32), .RF_WIDTH(5), .EXEC_WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (rob_bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- program-order model ----------------
  typedef struct {
    int          tag;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  eid;
    bit          st;
    bit          done;
    logic [31:0] data;
  } ent_t;

  ent_t m_q[$];
  int   m_next_tag = 0;
  bit   chk_en = 1'b0;
  bit   m_ret;
  bit   m_alc;
  ent_t m_new;

  always @(posedge clk) begin
    if (!rst || flush) begin
      m_q.delete();
      m_next_tag = 0;
    end else begin
      m_ret = (m_q.size() > 0) && m_q[0].done && rob_bus.commit_ready;
      m_alc = (rob_bus.RType_valid_ROB || rob_bus.IType_valid_ROB || rob_bus.SType_valid_ROB)
              && (m_q.size() < 16);
      if (rob_bus.wb_valid)
        foreach (m_q[k])
          if (m_q[k].tag == int'(rob_bus.wb_tag)) begin
            m_q[k].done = 1'b1;
            m_q[k].data = rob_bus.wb_data;
          end
      if (m_ret) void'(m_q.pop_front());
      if (m_alc) begin
        m_new.tag  = m_next_tag;
        m_new.rd   = rob_bus.rd_ROB;
        m_new.imm  = rob_bus.imm_ROB;
        m_new.eid  = rob_bus.executionID_ROB;
        m_new.st   = rob_bus.SType_valid_ROB;
        m_new.done = 1'b0;
        m_new.data = '0;
        m_q.push_back(m_new);
        m_next_tag = (m_next_tag + 1) % 16;
      end
    end
    chk_en = 1'b1;
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 64'(rob_bus.count), 64'(m_q.size()));
      chk("halt", 64'(rob_bus.halt), 64'(m_q.size() == 16));
      chk("alloc_tag", 64'(rob_bus.alloc_tag), 64'(m_next_tag));
      chk("commit_valid", 64'(rob_bus.commit_valid), 64'((m_q.size() > 0) && m_q[0].done));
      if ((m_q.size() > 0) && m_q[0].done) begin
        chk("commit_rd", 64'(rob_bus.commit_rd), 64'(m_q[0].rd));
        chk("commit_data", 64'(rob_bus.commit_data), 64'(m_q[0].data));
        chk("commit_imm", 64'(rob_bus.commit_imm), 64'(m_q[0].imm));
        chk("commit_is_store", 64'(rob_bus.commit_is_store), 64'(m_q[0].st));
        chk("commit_execID", 64'(rob_bus.commit_execID), 64'(m_q[0].eid));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rob_bus.RType_valid_ROB = 1'b0;
    rob_bus.IType_valid_ROB = 1'b0;
    rob_bus.SType_valid_ROB = 1'b0;
    rob_bus.rd_ROB          = '0;
    rob_bus.imm_ROB         = '0;
    rob_bus.executionID_ROB = '0;
    rob_bus.wb_valid        = 1'b0;
    rob_bus.wb_tag          = '0;
    rob_bus.wb_data         = '0;
  endtask

  // kind: 0=R, 1=I, 2=S
  task automatic present(input int kind, input logic [4:0] rd, input logic [31:0] imm,
                         input logic [3:0] eid);
    rob_bus.RType_valid_ROB = (kind == 0);
    rob_bus.IType_valid_ROB = (kind == 1);
    rob_bus.SType_valid_ROB = (kind == 2);
    rob_bus.rd_ROB          = rd;
    rob_bus.imm_ROB         = imm;
    rob_bus.executionID_ROB = eid;
  endtask

  task automatic novalid();
    rob_bus.RType_valid_ROB = 1'b0;
    rob_bus.IType_valid_ROB = 1'b0;
    rob_bus.SType_valid_ROB = 1'b0;
  endtask

  task automatic wb(input logic [3:0] tag, input logic [31:0] data);
    rob_bus.wb_valid = 1'b1;
    rob_bus.wb_tag   = tag;
    rob_bus.wb_data  = data;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    rob_bus.commit_ready = 1'b1;

    // 1. Reset held two cycles with inputs active
    present(0, 5'd7, 32'h1234, 4'd3);
    wb(4'd0, 32'hFFFF);
    cyc();
    cyc();
    chk("rst_count", 64'(rob_bus.count), 64'd0);
    chk("rst_halt", 64'(rob_bus.halt), 64'd0);
    chk("rst_commit_valid", 64'(rob_bus.commit_valid), 64'd0);
    chk("rst_alloc_tag", 64'(rob_bus.alloc_tag), 64'd0);
    idle();
    rst = 1'b1;

    // 2. Single R-type op
    present(0, 5'd5, 32'h11, 4'd2);
    cyc();
    idle();
    chk("t2_count1", 64'(rob_bus.count), 64'd1);
    chk("t2_not_done", 64'(rob_bus.commit_valid), 64'd0);
    wb(4'd0, 32'hDEAD);
    cyc();
    rob_bus.wb_valid = 1'b0;
    chk("t2_commit_valid", 64'(rob_bus.commit_valid), 64'd1);
    chk("t2_commit_rd", 64'(rob_bus.commit_rd), 64'd5);
    chk("t2_commit_data", 64'(rob_bus.commit_data), 64'hDEAD);
    cyc();
    chk("t2_count0", 64'(rob_bus.count), 64'd0);

    // 3. Fill 16 with no writeback, then a 17th attempt
    do_reset();
    rob_bus.commit_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      present(i % 3, 5'(i + 1), 32'(100 + i), 4'(i));
      cyc();
    end
    chk("t3_count16", 64'(rob_bus.count), 64'd16);
    chk("t3_halt", 64'(rob_bus.halt), 64'd1);
    chk("t3_tag_wrap", 64'(rob_bus.alloc_tag), 64'd0);
    present(0, 5'd31, 32'hBAD, 4'd15);
    cyc();
    chk("t3_no_alloc17", 64'(rob_bus.count), 64'd16);

    // 5. Full: retire head while a valid is presented
    novalid();
    wb(4'd0, 32'hCAFE);
    cyc();
    rob_bus.wb_valid = 1'b0;
    rob_bus.commit_ready = 1'b1;
    present(1, 5'd30, 32'h77, 4'd9);
    cyc();
    novalid();
    chk("t5_count15", 64'(rob_bus.count), 64'd15);
    chk("t5_halt_low", 64'(rob_bus.halt), 64'd0);
    chk("t5_tag", 64'(rob_bus.alloc_tag), 64'd0);

    // 4. Out-of-order writeback, in-order commit
    do_reset();
    rob_bus.commit_ready = 1'b1;
    present(0, 5'd1, 32'hA1, 4'd1); cyc();
    present(1, 5'd2, 32'hA2, 4'd2); cyc();
    present(2, 5'd3, 32'hA3, 4'd3);
    rob_bus.RType_valid_ROB = 1'b1;   // S must win over R
    cyc();
    novalid();
    wb(4'd2, 32'h222); cyc();
    chk("t4_wait2", 64'(rob_bus.commit_valid), 64'd0);
    wb(4'd1, 32'h111); cyc();
    chk("t4_wait1", 64'(rob_bus.commit_valid), 64'd0);
    wb(4'd0, 32'h100); cyc();
    rob_bus.wb_valid = 1'b0;
    chk("t4_c0_rd", 64'(rob_bus.commit_rd), 64'd1);
    cyc();
    chk("t4_c1_rd", 64'(rob_bus.commit_rd), 64'd2);
    chk("t4_c1_data", 64'(rob_bus.commit_data), 64'h111);
    cyc();
    chk("t4_c2_rd", 64'(rob_bus.commit_rd), 64'd3);
    chk("t4_c2_store", 64'(rob_bus.commit_is_store), 64'd1);
    cyc();
    chk("t4_empty", 64'(rob_bus.count), 64'd0);

    // 6. Flush with 7 entries, 3 done
    do_reset();
    rob_bus.commit_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      present(i % 3, 5'(10 + i), 32'(i), 4'(i));
      cyc();
    end
    novalid();
    for (int i = 1; i < 6; i += 2) begin
      wb(4'(i), 32'(32'h500 + i));
      cyc();
    end
    rob_bus.wb_valid = 1'b0;
    chk("t6_pre_count", 64'(rob_bus.count), 64'd7);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("t6_count0", 64'(rob_bus.count), 64'd0);
    chk("t6_cv0", 64'(rob_bus.commit_valid), 64'd0);
    wb(4'd0, 32'hBEEF);
    cyc();
    rob_bus.wb_valid = 1'b0;
    chk("t6_late_wb", 64'(rob_bus.commit_valid), 64'd0);
    chk("t6_next_tag", 64'(rob_bus.alloc_tag), 64'd0);
    present(0, 5'd20, 32'h55, 4'd4);
    cyc();
    novalid();
    chk("t6_new_notdone", 64'(rob_bus.commit_valid), 64'd0);
    rob_bus.commit_ready = 1'b1;
    wb(4'd0, 32'h600);
    cyc();
    rob_bus.wb_valid = 1'b0;
    chk("t6_new_rd", 64'(rob_bus.commit_rd), 64'd20);
    chk("t6_new_data", 64'(rob_bus.commit_data), 64'h600);
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
